// File: rtl/input_conditioner.sv
// input_conditioner: per-bit 2-FF synchronizer, tick-sampled debounce, edge pulses and sticky event flags.
// Optional auto-repeat of rise pulses while a bit is held high: define INCON_REPEAT_EN.

module input_conditioner_lane #(
  parameter int STABLE    = 8
`ifdef INCON_REPEAT_EN
  ,
  parameter int REP_DELAY = 500,
  parameter int REP_RATE  = 100
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic s_i,
  input  logic clr_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o
);
  logic [7:0] c_q, c_d;
  logic       q_q, q_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       evt_q, evt_d;
  logic       accept;
  logic       rep_fire;

  assign accept = tick_i && (s_i != q_q) && (c_q == 8'(STABLE - 1));

`ifdef INCON_REPEAT_EN
  logic [15:0] r_q, r_d, r_inc, r_tgt;
  logic        armed_q, armed_d;

  // First target is REP_DELAY, then REP_RATE between repeats; never fires on the tick that accepts a fall.
  always_comb begin
    r_inc    = r_q + 16'd1;
    r_tgt    = armed_q ? 16'(REP_RATE) : 16'(REP_DELAY);
    r_d      = r_q;
    armed_d  = armed_q;
    rep_fire = 1'b0;
    if (!q_q) begin
      r_d     = '0;
      armed_d = 1'b0;
    end else if (tick_i && !accept) begin
      if (r_inc == r_tgt) begin
        rep_fire = 1'b1;
        r_d      = '0;
        armed_d  = 1'b1;
      end else begin
        r_d = r_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      armed_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      armed_q <= armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    c_d    = c_q;
    q_d    = q_q;
    rise_d = rep_fire;
    fall_d = 1'b0;
    if (tick_i) begin
      if (s_i == q_q) begin
        c_d = '0;
      end else if (accept) begin
        c_d    = '0;
        q_d    = s_i;
        rise_d = s_i;
        fall_d = ~s_i;
      end else begin
        c_d = c_q + 8'd1;
      end
    end
  end

  // A set in the same cycle as a clear wins.
  always_comb begin
    evt_d = evt_q;
    if (rise_q)     evt_d = 1'b1;
    else if (clr_i) evt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q    <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = evt_q;
endmodule

module input_conditioner #(
  parameter int WIDTH     = 12,
  parameter int DIV       = 100000,
  parameter int STABLE    = 8,
  parameter int REP_DELAY = 500,
  parameter int REP_RATE  = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  output logic             tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] s1_q, s2_q;

  // Out-of-range settings elaborate this empty marker block so they show up in the hierarchy.
  if (DIV < 1 || STABLE < 2 || STABLE > 255 || REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_cfg
  end

  assign tick  = (pre_q == CW'(DIV - 1));
  assign pre_d = tick ? '0 : pre_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      pre_q <= pre_d;
      s1_q  <= din;
      s2_q  <= s1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    input_conditioner_lane #(
      .STABLE    (STABLE)
`ifdef INCON_REPEAT_EN
      ,
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
`endif
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .tick_i (tick),
      .s_i    (s2_q[i]),
      .clr_i  (clr[i]),
      .q_o    (q[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i]),
      .evt_o  (evt[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: expected rise/fall pulses (bit, kind, tick index) are queued when din is
// driven and matched as pulses appear; q/evt/tick/reset behaviour is checked directly.
`timescale 1ns/1ps
module tb_input_conditioner;
  localparam int WIDTH = 4, DIV = 4, STABLE = 3, REP_DELAY = 5, REP_RATE = 2;

  logic             clk = 1'b0, reset = 1'b1;
  logic [WIDTH-1:0] din = '0, clr = '0;
  logic [WIDTH-1:0] q, rise, fall, evt;
  logic             tick;

  input_conditioner #(.WIDTH(WIDTH), .DIV(DIV), .STABLE(STABLE),
                      .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) dut (
    .clk(clk), .reset(reset), .din(din), .clr(clr),
    .q(q), .rise(rise), .fall(fall), .evt(evt), .tick(tick));

  always #5 clk = ~clk;

  typedef struct { int b; bit r; int t; } pulse_t;
  pulse_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ntick = 0;
  bit tk_now = 1'b0;

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Clock edges since reset release; tick is due when this is DIV-1 mod DIV.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic match(int b, bit r);
    int idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].b == b && sb[i].r == r) idx = i;
    if (idx < 0) chk($sformatf("spurious %s[%0d] @tick %0d", r ? "rise" : "fall", b, ntick), 1, 0);
    else begin
      chk($sformatf("%s[%0d] tick", r ? "rise" : "fall", b), ntick, sb[idx].t);
      sb.delete(idx);
    end
  endtask

  initial forever begin
    @(negedge clk);
    tk_now = 1'b0;
    if (reset) ntick = 0;
    else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (rise[b]) match(b, 1'b1);
        if (fall[b]) match(b, 1'b0);
      end
      tk_now = (cyc % DIV == DIV - 1);
      chk("tick", tick, tk_now);
      if (tk_now) ntick++;
    end
  end

  task automatic push(int b, bit r, int t);
    pulse_t p;
    p.b = b; p.r = r; p.t = t;
    sb.push_back(p);
  endtask

  task automatic expect_rise(int b, int a);
    push(b, 1'b1, a);
`ifdef INCON_REPEAT_EN
    for (int t = a + REP_DELAY; t < a + REP_DELAY + REP_RATE * 64; t += REP_RATE) push(b, 1'b1, t);
`endif
  endtask

  // Drive only right after a tick: the first differing sample is then the next tick.
  task automatic press(int b);
    din[b] = 1'b1;
    expect_rise(b, ntick + STABLE);
  endtask

  task automatic release_bit(int b);
    int f = ntick + STABLE;
    din[b] = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].b == b && sb[i].r && sb[i].t >= f) sb.delete(i);
    push(b, 1'b0, f);
  endtask

  task automatic check_missed();
    foreach (sb[i])
      if (sb[i].t <= ntick)
        chk($sformatf("missed %s[%0d] @tick %0d", sb[i].r ? "rise" : "fall", sb[i].b, sb[i].t), 0, 1);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic to_tick();
    do step(); while (!tk_now);
  endtask

  task automatic ticks(int n);
    repeat (n) to_tick();
  endtask

  task automatic wait_until(int t);
    while (ntick < t) to_tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    #1;
    chk("rst q", q, 0);   chk("rst rise", rise, 0); chk("rst fall", fall, 0);
    chk("rst evt", evt, 0); chk("rst tick", tick, 0);
    step(); step();

    // 1: release; the release cycle counts as cycle 1, the tick lands on cycle DIV
    reset = 1'b0;
    n = 1;
    do begin step(); n++; end while (!tk_now && n < 20);
    chk("first tick cycle", n, DIV);
    ticks(2);
    chk("idle q", q, 0); chk("idle evt", evt, 0);

    // 2: press bit 0, accept on third tick, evt sticky until clr
    to_tick(); k = ntick; press(0);
    wait_until(k + STABLE - 1);
    chk("q0 not early", q[0], 0);
    wait_until(k + STABLE); step();
    chk("q0 accepted", q[0], 1);
    chk("evt0 not yet", evt[0], 0);
    step();
    chk("evt0 set", evt[0], 1);
    repeat (5) step();
    chk("evt0 held", evt[0], 1);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    chk("evt0 cleared", evt[0], 0);

    // 3: 2-tick glitch on bit 1 rejected, then bit 0 released
    to_tick(); din[1] = 1'b1; ticks(2); din[1] = 1'b0; ticks(4);
    chk("glitch q1", q[1], 0); chk("glitch evt1", evt[1], 0);
    release_bit(0); ticks(4);
    chk("q0 released", q[0], 0);

    // 4: clr coincident with rise loses; lone clr then clears
    to_tick(); k = ntick; press(2);
    wait_until(k + STABLE); step();
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("evt2 set beats clr", evt[2], 1);
    step();
    chk("evt2 still set", evt[2], 1);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("evt2 lone clr", evt[2], 0);
    to_tick(); release_bit(2); ticks(4);

    // 5: reset mid-count on bit 3 (bit 1 already accepted), inputs held through reset
    to_tick(); press(1); to_tick(); k = ntick; din[3] = 1'b1;
    wait_until(k + 2); step(); step(); step();
    chk("pre-reset q", q, 4'b0010); chk("pre-reset evt1", evt[1], 1);
    reset = 1'b1; #1;
    chk("async rst q", q, 0); chk("async rst evt", evt, 0); chk("async rst tick", tick, 0);
    check_missed(); sb.delete();
    step(); step();
    reset = 1'b0;
    expect_rise(1, STABLE); expect_rise(3, STABLE);
    wait_until(STABLE - 1);
    chk("q3 not early after rst", q[3], 0);
    wait_until(STABLE); step();
    chk("held bits accepted", q, 4'b1010);
    to_tick(); release_bit(1); release_bit(3); ticks(4);
    chk("q after releases", q, 0);

    // 6: long hold on bit 2 (repeats only with the optional feature)
    to_tick(); k = ntick; press(2);
    wait_until(k + 10); release_bit(2); ticks(5);
    chk("q2 released", q[2], 0);

    ticks(2);
    check_missed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
